instr_fetch_unit: RTL and testbench

//  Producer side of the main_control opcode interface: fetches 32-bit RISC-V words from

---
 rtl/instr_fetch_unit.sv | 122 ++++++++++++
 tb/tb_instr_fetch_unit.sv | 296 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/instr_fetch_unit.sv
// Instruction fetch unit: fetches words from imem over req/ack, buffers them in a small FIFO
// for decode, and restarts fetch on branch/jump redirects from execute.
module instr_fetch_unit #(
    parameter int unsigned     XLEN       = 32,
    parameter logic [XLEN-1:0] RESET_PC   = '0,
    parameter int unsigned     FIFO_DEPTH = 2
) (
    input  logic            clk,
    input  logic            reset,
    output logic            imem_req,
    output logic [XLEN-1:0] imem_addr,
    input  logic            imem_ack,
    input  logic [31:0]     imem_rdata,
    input  logic            redirect,
    input  logic [XLEN-1:0] redirect_pc,
    output logic            inst_valid,
    input  logic            inst_ready,
    output logic [31:0]     inst,
    output logic [XLEN-1:0] inst_pc,
    output logic [6:0]      opcode
);
    localparam int unsigned PW      = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int unsigned CW      = PW + 1;
    localparam logic [31:0] NOP     = 32'h0000_0013;
    localparam logic [CW-1:0] DEPTH_C = CW'(FIFO_DEPTH);

    typedef enum logic [1:0] {S_IDLE, S_REQ, S_KILL} state_t;

    state_t          state, state_next;
    logic [XLEN-1:0] pc, pc_next, kill_addr;
    logic [31:0]     data_mem [FIFO_DEPTH];
    logic [XLEN-1:0] pc_mem   [FIFO_DEPTH];
    logic [PW-1:0]   wr_ptr, rd_ptr;
    logic [CW-1:0]   count, count_after_push;
    logic            push, pop;
    logic [XLEN-1:0] redirect_aligned;

    assign redirect_aligned = redirect_pc & ~XLEN'(3);
    assign inst_valid       = (count != '0);
    assign pop              = inst_valid && inst_ready && !redirect;
    assign count_after_push = count + CW'(1) - CW'(pop);

    assign inst      = inst_valid ? data_mem[rd_ptr] : NOP;
    assign inst_pc   = inst_valid ? pc_mem[rd_ptr] : RESET_PC;
    assign opcode    = inst[6:0];
    assign imem_req  = (state != S_IDLE);
    // A killed request keeps presenting the address it was issued with until imem acks.
    assign imem_addr = (state == S_KILL) ? kill_addr : pc;

    always_comb begin
        state_next = state;
        pc_next    = pc;
        push       = 1'b0;
        case (state)
            S_IDLE: begin
                if (redirect) begin
                    pc_next    = redirect_aligned;
                    state_next = S_REQ;
                end else if (count < DEPTH_C) begin
                    state_next = S_REQ;
                end
            end
            S_REQ: begin
                if (redirect) begin
                    pc_next    = redirect_aligned;
                    state_next = imem_ack ? S_IDLE : S_KILL;
                end else if (imem_ack) begin
                    push       = 1'b1;
                    pc_next    = pc + XLEN'(4);
                    state_next = (count_after_push < DEPTH_C) ? S_REQ : S_IDLE;
                end
            end
            S_KILL: begin
                if (redirect) begin
                    pc_next = redirect_aligned;
                end
                if (imem_ack) begin
                    state_next = S_IDLE;
                end
            end
            default: state_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state     <= S_IDLE;
            pc        <= RESET_PC;
            kill_addr <= RESET_PC;
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            count     <= '0;
        end else begin
            state <= state_next;
            pc    <= pc_next;
            if (state == S_REQ && redirect && !imem_ack) begin
                kill_addr <= pc;
            end
            // Redirect wins over any push or pop in the same cycle.
            if (redirect) begin
                wr_ptr <= '0;
                rd_ptr <= '0;
                count  <= '0;
            end else begin
                if (push) begin
                    wr_ptr <= wr_ptr + PW'(1);
                end
                if (pop) begin
                    rd_ptr <= rd_ptr + PW'(1);
                end
                count <= count + CW'(push) - CW'(pop);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            data_mem[wr_ptr] <= imem_rdata;
            pc_mem[wr_ptr]   <= pc;
        end
    end
endmodule

// File: tb/tb_instr_fetch_unit.sv
// Scoreboard bench for instr_fetch_unit: a randomized imem responder and decode sink,
// checked against a program-order model of which PCs must reach decode.
module tb_instr_fetch_unit;
    localparam int unsigned FIFO_DEPTH = 2;
    localparam logic [31:0] RESET_PC   = 32'h0000_0000;
    localparam logic [31:0] NOP        = 32'h0000_0013;

    logic        clk;
    logic        reset;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ack;
    logic [31:0] imem_rdata;
    logic        redirect;
    logic [31:0] redirect_pc;
    logic        inst_valid;
    logic        inst_ready;
    logic [31:0] inst;
    logic [31:0] inst_pc;
    logic [6:0]  opcode;

    instr_fetch_unit #(
        .XLEN(32),
        .RESET_PC(RESET_PC),
        .FIFO_DEPTH(FIFO_DEPTH)
    ) dut (
        .clk(clk),
        .reset(reset),
        .imem_req(imem_req),
        .imem_addr(imem_addr),
        .imem_ack(imem_ack),
        .imem_rdata(imem_rdata),
        .redirect(redirect),
        .redirect_pc(redirect_pc),
        .inst_valid(inst_valid),
        .inst_ready(inst_ready),
        .inst(inst),
        .inst_pc(inst_pc),
        .opcode(opcode)
    );

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] data;
    } exp_t;

    exp_t        exp_q[$];
    int          compared = 0;
    int          mismatched = 0;
    int          delivered = 0;
    bit          monitor_on = 0;
    bit          push_pending = 0;
    bit          outstanding = 0;
    bit          killed = 0;
    int          remaining = 0;
    logic [31:0] start_addr = '0;
    logic [31:0] model_pc = RESET_PC;
    int          idle_run = 0;
    int          edges_since_release = 0;
    bit          first_valid_seen = 0;
    bit          check_latency = 0;
    int          fixed_delay = 1;
    int          ready_pct = 100;
    int          redirect_pct = 0;
    bit          redir_now = 0;
    bit          redir_at_req_start = 0;
    bit          force_redir_on_ack = 0;
    logic [31:0] redir_pc_now = '0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [31:0] memWord(input logic [31:0] a);
        return (a * 32'h9E37_79B1) ^ 32'h5A5A_3C3C;
    endfunction

    function automatic logic [31:0] randomPc();
        int          sel;
        logic [31:0] r;
        sel = $urandom_range(0, 3);
        r   = $urandom;
        case (sel)
            0:       return r;
            1:       return 32'hFFFF_FFF0 | (r & 32'h0000_000F);
            default: return r & 32'h0000_03FF;
        endcase
    endfunction

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        compared++;
        if (actual !== expected) begin
            mismatched++;
            $display("[TB] FAIL %s: actual=%h required=%h at %0t", name, actual, expected, $time);
        end
    endtask

    task automatic doReset();
        @(posedge clk);
        #3;
        reset      = 1'b1;
        imem_ack   = 1'b0;
        redirect   = 1'b0;
        inst_ready = 1'b0;
        #1;
        checkOutput("rst_imem_req", imem_req, 0);
        checkOutput("rst_imem_addr", imem_addr, RESET_PC);
        checkOutput("rst_inst_valid", inst_valid, 0);
        checkOutput("rst_inst", inst, NOP);
        checkOutput("rst_inst_pc", inst_pc, RESET_PC);
        checkOutput("rst_opcode", opcode, 32'h13);
        exp_q.delete();
        model_pc     = RESET_PC;
        outstanding  = 0;
        killed       = 0;
        remaining    = 0;
        push_pending = 0;
        idle_run     = 0;
        repeat (2) @(posedge clk);
        #3;
        reset               = 1'b0;
        edges_since_release = 0;
        first_valid_seen    = 0;
    endtask

    // One clock of imem responder + decode sink; the model learns what the next edge does.
    task automatic applyStimulus();
        bit          do_ack;
        bit          do_redir;
        bit          started;
        logic [31:0] rpc;
        exp_t        e;
        @(posedge clk);
        #1;
        push_pending = 0;
        started      = 0;
        edges_since_release++;
        if (!first_valid_seen && inst_valid) begin
            first_valid_seen = 1;
            if (check_latency) checkOutput("first_valid_latency", edges_since_release, 3);
        end
        if (outstanding) begin
            checkOutput("req_held", imem_req, 1);
            checkOutput("addr_stable", imem_addr, start_addr);
        end else if (imem_req) begin
            outstanding = 1;
            started     = 1;
            start_addr  = imem_addr;
            checkOutput("req_addr", imem_addr, model_pc);
            remaining = (fixed_delay >= 0) ? fixed_delay : $urandom_range(0, 3);
        end
        if (exp_q.size() >= FIFO_DEPTH) checkOutput("full_req_low", imem_req, 0);
        if (!imem_req && exp_q.size() < FIFO_DEPTH) begin
            idle_run++;
            checkOutput("idle_with_space", idle_run <= 1, 1);
        end else begin
            idle_run = 0;
        end

        do_ack = outstanding && (remaining == 0);
        if (outstanding && remaining > 0) remaining--;
        inst_ready = ($urandom_range(0, 99) < ready_pct);
        do_redir   = ($urandom_range(0, 99) < redirect_pct);
        rpc        = randomPc();
        if (redir_now || (redir_at_req_start && started)) begin
            do_redir           = 1;
            rpc                = redir_pc_now;
            redir_now          = 0;
            redir_at_req_start = 0;
        end
        if (force_redir_on_ack && do_ack && exp_q.size() > 0) begin
            do_redir           = 1;
            inst_ready         = 1'b1;
            rpc                = randomPc();
            force_redir_on_ack = 0;
        end
        imem_ack    = do_ack;
        imem_rdata  = do_ack ? memWord(start_addr) : $urandom;
        redirect    = do_redir;
        redirect_pc = do_redir ? rpc : $urandom;

        if (do_redir) begin
            exp_q.delete();
            model_pc = rpc & ~32'h3;
            if (!do_ack && outstanding) killed = 1;
        end else if (do_ack && !killed) begin
            e.pc   = model_pc;
            e.data = memWord(model_pc);
            exp_q.push_back(e);
            push_pending = 1;
            model_pc     = model_pc + 32'd4;
        end
        if (do_ack) begin
            outstanding = 0;
            killed      = 0;
        end
    endtask

    // Monitor: compares the decode-facing outputs against the scoreboard head every cycle.
    always @(negedge clk) begin
        int vis;
        if (monitor_on && !reset && !redirect) begin
            vis = exp_q.size() - (push_pending ? 1 : 0);
            checkOutput("inst_valid", inst_valid, vis > 0);
            if (vis > 0) begin
                checkOutput("inst", inst, exp_q[0].data);
                checkOutput("inst_pc", inst_pc, exp_q[0].pc);
                checkOutput("opcode", opcode, exp_q[0].data[6:0]);
                if (inst_valid && inst_ready) begin
                    void'(exp_q.pop_front());
                    delivered++;
                end
            end else begin
                checkOutput("empty_inst", inst, NOP);
                checkOutput("empty_inst_pc", inst_pc, RESET_PC);
            end
        end
    end

    initial begin
        int waited;
        reset       = 1'b1;
        imem_ack    = 1'b0;
        imem_rdata  = '0;
        redirect    = 1'b0;
        redirect_pc = '0;
        inst_ready  = 1'b0;
        doReset();
        monitor_on = 1;

        $display("[TB] streaming");
        fixed_delay   = 1;
        ready_pct     = 100;
        check_latency = 1;
        repeat (20) applyStimulus();
        check_latency = 0;

        $display("[TB] backpressure");
        ready_pct = 0;
        repeat (12) applyStimulus();
        checkOutput("bp_fifo_full", exp_q.size(), FIFO_DEPTH);
        checkOutput("bp_req_low", imem_req, 0);
        ready_pct = 100;
        repeat (10) applyStimulus();

        $display("[TB] redirect while idle and full");
        ready_pct = 0;
        repeat (8) applyStimulus();
        redir_now    = 1;
        redir_pc_now = 32'h0000_0100;
        applyStimulus();
        ready_pct = 100;
        repeat (10) applyStimulus();

        $display("[TB] redirect with request outstanding");
        fixed_delay        = 3;
        redir_at_req_start = 1;
        redir_pc_now       = 32'h0000_0200;
        repeat (14) applyStimulus();

        $display("[TB] boundaries");
        fixed_delay  = 0;
        redir_now    = 1;
        redir_pc_now = 32'hFFFF_FFFC;
        repeat (8) applyStimulus();
        redir_now    = 1;
        redir_pc_now = 32'h0000_0103;
        repeat (8) applyStimulus();
        fixed_delay        = 1;
        force_redir_on_ack = 1;
        repeat (10) applyStimulus();
        force_redir_on_ack = 0;

        $display("[TB] random traffic");
        fixed_delay  = -1;
        ready_pct    = 70;
        redirect_pct = 4;
        repeat (3000) applyStimulus();

        $display("[TB] async reset mid-request");
        waited = 0;
        while (!outstanding && waited < 20) begin
            applyStimulus();
            waited++;
        end
        doReset();
        repeat (1000) applyStimulus();

        redirect_pct = 0;
        ready_pct    = 100;
        repeat (20) applyStimulus();
        checkOutput("delivered_progress", delivered > 200, 1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end
endmodule
